// File: rtl/cvxif_group_dispatcher.sv
// CV-X-IF group dispatcher: decodes custom-0 FILL/EXEC/PICK instructions into an in-order
// command queue and strobes the group array one command per cycle. Optional stall counter: CVXIF_DISPATCH_STALL_CNT_EN.
module cvxif_group_dispatcher #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ID_W       = 3,
    parameter int unsigned OPCODE_W   = 7,
    parameter int unsigned IDX_W      = 5,
    parameter int unsigned DEPTH      = 4,
    parameter logic [6:0]  CUSTOM_OPC = 7'h0B
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_W-1:0]     issue_id_i,
    input  logic [XLEN-1:0]     rs1_i,
    input  logic [XLEN-1:0]     rs2_i,
    output logic                issue_accept_o,
    input  logic                kill_i,
    input  logic                busy_i,
    output logic [OPCODE_W-1:0] opcode_o,
    output logic [ID_W-1:0]     instr_id_o,
    output logic                exec_o,
    output logic                in_data_vld_o,
    output logic [IDX_W-1:0]    in_idx_o,
    output logic [2*XLEN-1:0]   in_data_o,
    output logic                out_data_vld_o,
    output logic [IDX_W-1:0]    out_idx_o,
    output logic                empty_o
`ifdef CVXIF_DISPATCH_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt_o
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        KIND_FILL = 2'd0,
        KIND_EXEC = 2'd1,
        KIND_PICK = 2'd2
    } kind_t;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic                dec_legal;
    kind_t               dec_kind;
    logic [OPCODE_W-1:0] dec_opcode;
    logic [IDX_W-1:0]    dec_idx;
    logic                unused_instr_bits;

    always_comb begin
        dec_legal = 1'b0;
        dec_kind  = KIND_FILL;
        if (issue_instr_i[6:0] == CUSTOM_OPC) begin
            case (issue_instr_i[14:12])
                3'b000: begin dec_legal = 1'b1; dec_kind = KIND_FILL; end
                3'b001: begin dec_legal = 1'b1; dec_kind = KIND_EXEC; end
                3'b010: begin dec_legal = 1'b1; dec_kind = KIND_PICK; end
                default: begin dec_legal = 1'b0; dec_kind = KIND_FILL; end
            endcase
        end
    end

    assign dec_opcode = OPCODE_W'(issue_instr_i[31:25]);
    // FILL addresses from the rd field, PICK from the low bits of rs1
    assign dec_idx    = (dec_kind == KIND_PICK) ? rs1_i[IDX_W-1:0] : IDX_W'(issue_instr_i[11:7]);
    assign unused_instr_bits = ^issue_instr_i[24:15];

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             empty;
    logic             push;
    logic             fire;

    // Reset forces the queue to look empty so nothing dispatches while rst_i is high
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0) || rst_i;

    assign issue_ready_o  = !full && !rst_i;
    assign issue_accept_o = dec_legal;
    assign push           = issue_valid_i && issue_ready_o && dec_legal && !kill_i;
    assign fire           = !empty && !busy_i && !kill_i;
    assign empty_o        = empty;

    always_ff @(posedge clk_i) begin
        if (rst_i || kill_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (fire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, fire})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Payload storage (not reset)
    // ------------------------------------------------------------------
    logic [1:0]          kind_mem   [DEPTH];
    logic [OPCODE_W-1:0] opcode_mem [DEPTH];
    logic [ID_W-1:0]     id_mem     [DEPTH];
    logic [IDX_W-1:0]    idx_mem    [DEPTH];
    logic [XLEN-1:0]     rs1_mem    [DEPTH];
    logic [XLEN-1:0]     rs2_mem    [DEPTH];

    always_ff @(posedge clk_i) begin
        if (push) begin
            kind_mem[wr_ptr_reg]   <= dec_kind;
            opcode_mem[wr_ptr_reg] <= dec_opcode;
            id_mem[wr_ptr_reg]     <= issue_id_i;
            idx_mem[wr_ptr_reg]    <= dec_idx;
            rs1_mem[wr_ptr_reg]    <= rs1_i;
            rs2_mem[wr_ptr_reg]    <= rs2_i;
        end
    end

    // ------------------------------------------------------------------
    // Head presentation and strobes
    // ------------------------------------------------------------------
    logic [1:0] head_kind;
    logic [2:0] strobe_vec;

    assign head_kind = kind_mem[rd_ptr_reg];

    assign opcode_o   = empty ? '0 : opcode_mem[rd_ptr_reg];
    assign instr_id_o = empty ? '0 : id_mem[rd_ptr_reg];
    assign in_idx_o   = empty ? '0 : idx_mem[rd_ptr_reg];
    assign out_idx_o  = empty ? '0 : idx_mem[rd_ptr_reg];
    assign in_data_o  = empty ? '0 : {rs2_mem[rd_ptr_reg], rs1_mem[rd_ptr_reg]};

    // One strobe per command kind; only the head's kind can see fire
    for (genvar gi = 0; gi < 3; gi++) begin : g_strobe
        assign strobe_vec[gi] = fire && (head_kind == 2'(gi));
    end

    assign in_data_vld_o  = strobe_vec[KIND_FILL];
    assign exec_o         = strobe_vec[KIND_EXEC];
    assign out_data_vld_o = strobe_vec[KIND_PICK];

`ifdef CVXIF_DISPATCH_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else if (!empty && busy_i && !kill_i && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_cvxif_group_dispatcher.sv
// Directed self-checking bench for cvxif_group_dispatcher; inputs change on the falling edge,
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_cvxif_group_dispatcher;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [2:0]  issue_id;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        issue_accept;
    logic        kill;
    logic        busy;
    logic [6:0]  opcode;
    logic [2:0]  instr_id;
    logic        exec_s;
    logic        in_data_vld;
    logic [4:0]  in_idx;
    logic [63:0] in_data;
    logic        out_data_vld;
    logic [4:0]  out_idx;
    logic        empty;
`ifdef CVXIF_DISPATCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int passed = 0;
    int total  = 0;

    cvxif_group_dispatcher dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .issue_valid_i  (issue_valid),
        .issue_ready_o  (issue_ready),
        .issue_instr_i  (issue_instr),
        .issue_id_i     (issue_id),
        .rs1_i          (rs1),
        .rs2_i          (rs2),
        .issue_accept_o (issue_accept),
        .kill_i         (kill),
        .busy_i         (busy),
        .opcode_o       (opcode),
        .instr_id_o     (instr_id),
        .exec_o         (exec_s),
        .in_data_vld_o  (in_data_vld),
        .in_idx_o       (in_idx),
        .in_data_o      (in_data),
        .out_data_vld_o (out_data_vld),
        .out_idx_o      (out_idx),
        .empty_o        (empty)
`ifdef CVXIF_DISPATCH_STALL_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rd,
                                       input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 5'd0, 5'd0, f3, rd, opc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [2:0] id,
                         input logic [31:0] a, input logic [31:0] b);
        issue_valid = 1'b1;
        issue_instr = instr;
        issue_id    = id;
        rs1         = a;
        rs2         = b;
    endtask

    // {exec, fill, pick}
    function automatic logic [2:0] strobes();
        return {exec_s, in_data_vld, out_data_vld};
    endfunction

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_instr = '0; issue_id = '0;
        rs1 = '0; rs2 = '0; kill = 1'b0; busy = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk); @(negedge clk); #1;
        chk("rst_ready", 64'(issue_ready), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_strobes", 64'(strobes()), 64'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("post_rst_ready", 64'(issue_ready), 64'd1);
        chk("post_rst_opcode", 64'(opcode), 64'd0);

        // ---------------- single FILL ----------------
        @(negedge clk); drive(mk(7'd5, 5'd3, 3'b000, 7'h0B), 3'd1, 32'hA, 32'hB); #1;
        chk("fill_accept", 64'(issue_accept), 64'd1);
        @(negedge clk); issue_valid = 1'b0; #1;
        chk("fill_strobes", 64'(strobes()), 64'b010);
        chk("fill_opcode", 64'(opcode), 64'd5);
        chk("fill_idx", 64'(in_idx), 64'd3);
        chk("fill_data", in_data, 64'h0000000B_0000000A);
        chk("fill_id", 64'(instr_id), 64'd1);
        @(negedge clk); #1;
        chk("fill_empty_after", 64'(empty), 64'd1);
        chk("fill_no_strobe", 64'(strobes()), 64'd0);

        // ---------------- EXEC held by busy ----------------
        @(negedge clk); busy = 1'b1; drive(mk(7'd9, 5'd0, 3'b001, 7'h0B), 3'd2, 32'h0, 32'h0); #1;
        chk("exec_accept", 64'(issue_accept), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); issue_valid = 1'b0; #1;
            chk($sformatf("busy_hold%0d", i), 64'({strobes(), opcode, instr_id}), 64'({3'b000, 7'd9, 3'd2}));
        end
        @(negedge clk); busy = 1'b0; #1;
        chk("exec_fire", 64'({strobes(), opcode, instr_id}), 64'({3'b100, 7'd9, 3'd2}));
`ifdef CVXIF_DISPATCH_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'd3);
`endif
        @(negedge clk); #1;
        chk("exec_empty_after", 64'(empty), 64'd1);

        // ---------------- fill the queue, hold a 5th ----------------
        @(negedge clk); busy = 1'b1; drive(mk(7'd1, 5'd4, 3'b000, 7'h0B), 3'd1, 32'h0, 32'h0);
        @(negedge clk); drive(mk(7'd2, 5'd0, 3'b001, 7'h0B), 3'd2, 32'h0, 32'h0);
        @(negedge clk); drive(mk(7'd3, 5'd0, 3'b010, 7'h0B), 3'd3, 32'h7, 32'h0);
        @(negedge clk); drive(mk(7'd4, 5'd6, 3'b000, 7'h0B), 3'd4, 32'h0, 32'h0); #1;
        chk("q3_ready", 64'(issue_ready), 64'd1);
        @(negedge clk); drive(mk(7'd6, 5'd0, 3'b001, 7'h0B), 3'd5, 32'h0, 32'h0); #1;
        chk("full_ready", 64'(issue_ready), 64'd0);
        @(negedge clk); busy = 1'b0; #1;
        chk("order0", 64'({strobes(), opcode, in_idx, issue_ready}), 64'({3'b010, 7'd1, 5'd4, 1'b0}));
        @(negedge clk); #1;
        chk("order1", 64'({strobes(), opcode, instr_id, issue_ready}), 64'({3'b100, 7'd2, 3'd2, 1'b1}));
        @(negedge clk); issue_valid = 1'b0; #1;
        chk("order2", 64'({strobes(), opcode, out_idx}), 64'({3'b001, 7'd3, 5'd7}));
        @(negedge clk); #1;
        chk("order3", 64'({strobes(), opcode, in_idx}), 64'({3'b010, 7'd4, 5'd6}));
        @(negedge clk); #1;
        chk("order4", 64'({strobes(), opcode, instr_id}), 64'({3'b100, 7'd6, 3'd5}));
        @(negedge clk); #1;
        chk("order_empty", 64'({empty, strobes()}), 64'({1'b1, 3'b000}));

        // ---------------- illegal requests ----------------
        @(negedge clk); drive(mk(7'd1, 5'd0, 3'b111, 7'h0B), 3'd1, 32'h0, 32'h0); #1;
        chk("ill_f3_accept", 64'({issue_accept, issue_ready}), 64'b01);
        @(negedge clk); drive(mk(7'd1, 5'd0, 3'b000, 7'h33), 3'd1, 32'h0, 32'h0); #1;
        chk("ill_opc_accept", 64'({issue_accept, issue_ready}), 64'b01);
        chk("ill_f3_not_queued", 64'({empty, strobes()}), 64'({1'b1, 3'b000}));
        @(negedge clk); issue_valid = 1'b0; #1;
        chk("ill_opc_not_queued", 64'({empty, strobes()}), 64'({1'b1, 3'b000}));

        // ---------------- kill with a concurrent request ----------------
        @(negedge clk); busy = 1'b1; drive(mk(7'd10, 5'd1, 3'b000, 7'h0B), 3'd1, 32'h0, 32'h0);
        @(negedge clk); drive(mk(7'd11, 5'd0, 3'b001, 7'h0B), 3'd2, 32'h0, 32'h0);
        @(negedge clk); drive(mk(7'd12, 5'd0, 3'b010, 7'h0B), 3'd3, 32'h0, 32'h0);
        @(negedge clk); busy = 1'b0; kill = 1'b1; drive(mk(7'd13, 5'd2, 3'b000, 7'h0B), 3'd4, 32'h0, 32'h0); #1;
        chk("kill_strobes", 64'({empty, opcode, strobes()}), 64'({1'b0, 7'd10, 3'b000}));
        @(negedge clk); kill = 1'b0; issue_valid = 1'b0; #1;
        chk("kill_empty", 64'({empty, strobes()}), 64'({1'b1, 3'b000}));
        @(negedge clk); #1;
        chk("kill_discard", 64'({empty, strobes(), opcode}), 64'({1'b1, 3'b000, 7'd0}));

        // ---------------- reset mid-burst ----------------
        @(negedge clk); busy = 1'b1; drive(mk(7'd20, 5'd1, 3'b000, 7'h0B), 3'd1, 32'h0, 32'h0);
        @(negedge clk); drive(mk(7'd21, 5'd0, 3'b001, 7'h0B), 3'd2, 32'h0, 32'h0);
        @(negedge clk); issue_valid = 1'b0; #1;
        chk("pre_rst_queued", 64'({empty, opcode}), 64'({1'b0, 7'd20}));
        @(negedge clk); rst = 1'b1; busy = 1'b0; #1;
        chk("mid_rst", 64'({issue_ready, empty, strobes()}), 64'({1'b0, 1'b1, 3'b000}));
        @(negedge clk); rst = 1'b0; #1;
        chk("after_rst", 64'({issue_ready, empty, strobes()}), 64'({1'b1, 1'b1, 3'b000}));
        @(negedge clk); #1;
        chk("after_rst_idle", 64'({empty, strobes()}), 64'({1'b1, 3'b000}));
        @(negedge clk); drive(mk(7'd22, 5'd0, 3'b001, 7'h0B), 3'd6, 32'h0, 32'h0);
        @(negedge clk); issue_valid = 1'b0; #1;
        chk("after_rst_new", 64'({strobes(), opcode, instr_id}), 64'({3'b100, 7'd22, 3'd6}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
